// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pulls len_i words from a 1-cycle-latency FIFO port into a credit-limited 2-entry buffer and streams them out with last tagging
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             rd_en_o,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic             empty_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] cnt_o,
  output logic             error_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] len_q, issued;
  logic [WIDTH-1:0] buf0, buf1;
  logic [1:0] occ;
  logic inflight, pop;
  always_ff @(posedge clk_i) state <= !rst_i ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (start_i ? (len_i == '0 ? DONE : RUN) : IDLE) :
               state == RUN  ? (pop && m_last_o ? DONE : RUN) : IDLE;
  always_comb begin
    pop = (occ != 2'd0) & m_ready_i;
    m_valid_o = occ != 2'd0;
    m_data_o = buf0;
    m_last_o = m_valid_o & (cnt_o == len_q - 1'b1);
    busy_o = state != IDLE;
    done_o = state == DONE;
    rd_en_o = (state == RUN) & !empty_i & (issued < len_q) &
              (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      len_q <= '0;
      issued <= '0;
      cnt_o <= '0;
      occ <= '0;
      inflight <= 1'b0;
      buf0 <= '0;
      buf1 <= '0;
      error_o <= 1'b0;
    end else begin
      inflight <= rd_en_o;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      if (pop) buf0 <= buf1;
      if (inflight) begin
        if (occ == {1'b0, pop}) buf0 <= rdata_i;
        else buf1 <= rdata_i;
      end
      if (start_i && state != IDLE) error_o <= 1'b1;
      if (start_i && state == IDLE) begin
        len_q <= len_i;
        issued <= '0;
        cnt_o <= '0;
      end else begin
        if (rd_en_o) issued <= issued + 1'b1;
        if (pop && cnt_o != len_q) cnt_o <= cnt_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: random/directed bursts against an in-order FIFO model and a word-log scoreboard
module tb_fifo_burst_reader;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_i = 0, start_i = 0, m_ready_i = 0, wr_en = 0, empty_i;
  logic [7:0] len_i = 0, rdata_i = 0, wr_data = 0;
  logic rd_en_o, m_valid_o, m_last_o, busy_o, done_o, error_o;
  logic [7:0] m_data_o, cnt_o;
  logic [7:0] mem [0:1023];
  int wp = 0, rp = 0, n_cmp = 0, n_bad = 0, exp_idx = 0, feed_gap = 1;
  logic [7:0] wlog[$];
  logic [7:0] feed_q[$];

  fifo_burst_reader #(.WIDTH(8), .LEN_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .rd_en_o(rd_en_o), .rdata_i(rdata_i), .empty_i(empty_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o),
    .error_o(error_o)
  );

  assign empty_i = (wp == rp);
  always @(posedge clk) begin
    if (rd_en_o) begin
      rdata_i <= mem[rp];
      rp <= rp + 1;
    end
    if (wr_en) begin
      mem[wp] <= wr_data;
      wp <= wp + 1;
    end
  end

  task automatic preload(input logic [7:0] w);
    wr_en = 1;
    wr_data = w;
    wlog.push_back(w);
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  // rmode: 0 ready always, 1 ready on odd cycles, 2 random ready
  task automatic run_burst(input int len, input int rmode, input int err_cyc, output int fv, output int dc);
    int hs, rds, lim, last_hs, cnt_done;
    logic pv, pl, pop, exp_rd;
    logic [7:0] pd;
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL idle_before_start busy_o=%b expected 0", busy_o); end
    fv = -1; dc = -1; hs = 0; rds = 0; pv = 0; pl = 0; pd = 0; last_hs = -1; cnt_done = -1;
    lim = 30 * len + 60;
    start_i = 1;
    len_i = 8'(len);
    @(posedge clk); #1;
    start_i = 0;
    for (int cyc = 1; cyc <= lim && dc < 0; cyc++) begin
      start_i = (cyc == err_cyc);
      m_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 2 == 1) : ($urandom_range(0, 2) != 0);
      wr_en = feed_q.size() > 0 && cyc % feed_gap == 0;
      if (wr_en) begin
        wr_data = feed_q.pop_front();
        wlog.push_back(wr_data);
      end
      @(negedge clk);
      pop = m_valid_o && m_ready_i;
      exp_rd = !empty_i && rds < len && (rds - hs - int'(pop)) < 2 && hs < len;
      n_cmp++;
      if (rd_en_o !== exp_rd) begin n_bad++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, rd_en_o, exp_rd); end
      if (rd_en_o) rds++;
      n_cmp++;
      if (busy_o !== 1'b1 || cnt_o !== 8'(hs)) begin
        n_bad++; $display("FAIL busy_cnt cyc=%0d busy=%b cnt=%0d exp busy=1 cnt=%0d", cyc, busy_o, cnt_o, hs);
      end
      if (pv) begin
        n_cmp++;
        if (m_valid_o !== 1'b1 || m_data_o !== pd || m_last_o !== pl) begin
          n_bad++; $display("FAIL hold cyc=%0d v=%b d=%h l=%b exp v=1 d=%h l=%b", cyc, m_valid_o, m_data_o, m_last_o, pd, pl);
        end
      end
      if (m_valid_o === 1'b1) begin
        if (fv < 0) fv = cyc;
        n_cmp++;
        if (m_data_o !== wlog[exp_idx] || m_last_o !== (hs == len - 1)) begin
          n_bad++; $display("FAIL data cyc=%0d d=%h l=%b exp d=%h l=%b", cyc, m_data_o, m_last_o, wlog[exp_idx], hs == len - 1);
        end
        if (m_ready_i) begin
          exp_idx++;
          hs++;
          last_hs = cyc;
        end
      end
      pv = m_valid_o && !m_ready_i;
      pd = m_data_o;
      pl = m_last_o;
      if (done_o === 1'b1) begin
        dc = cyc;
        cnt_done = int'(cnt_o);
      end
      @(posedge clk); #1;
    end
    start_i = 0;
    wr_en = 0;
    n_cmp++;
    if (dc < 0) begin n_bad++; $display("FAIL timeout len=%0d no done_o within %0d cycles", len, lim); end
    n_cmp++;
    if (hs != len || rds != len || dc != last_hs + 1) begin
      n_bad++; $display("FAIL counts hs=%0d reads=%0d done_cyc=%0d exp hs=reads=%0d done_cyc=%0d", hs, rds, dc, len, last_hs + 1);
    end
    n_cmp++;
    if (cnt_done != len || cnt_o !== 8'(len) || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++; $display("FAIL after_done cnt_at_done=%0d cnt=%0d busy=%b done=%b exp cnt=%0d busy=0 done=0", cnt_done, cnt_o, busy_o, done_o, len);
    end
  endtask

  task automatic test_reset;
    rst_i = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({rd_en_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o, cnt_o, error_o} !== '0) begin
      n_bad++; $display("FAIL reset rd=%b v=%b d=%h l=%b busy=%b done=%b cnt=%0d err=%b exp all 0",
        rd_en_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o, cnt_o, error_o);
    end
    @(posedge clk); #1;
    rst_i = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int fv, dc;
    for (int i = 0; i < 16; i++) preload(8'(i));
    run_burst(16, 0, 0, fv, dc);
    n_cmp++;
    if (fv != 3 || dc != 19 || error_o !== 1'b0) begin
      n_bad++; $display("FAIL basic_timing first_valid=%0d done=%0d err=%b exp 3 19 0", fv, dc, error_o);
    end
  endtask

  task automatic test_toggle;
    int fv, dc;
    for (int i = 0; i < 16; i++) preload(8'(i));
    run_burst(16, 1, 0, fv, dc);
  endtask

  task automatic test_empty_feed;
    int fv, dc;
    n_cmp++;
    if (empty_i !== 1'b1) begin n_bad++; $display("FAIL fifo_precondition empty=%b exp 1", empty_i); end
    feed_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    feed_gap = 5;
    run_burst(4, 0, 0, fv, dc);
    feed_gap = 1;
    n_cmp++;
    if (fv != 8 || dc != 24) begin
      n_bad++; $display("FAIL empty_feed_timing first_valid=%0d done=%0d exp 8 24", fv, dc);
    end
  endtask

  task automatic test_len0;
    for (int i = 0; i < 3; i++) preload(8'(8'h30 + i));
    start_i = 1;
    len_i = 0;
    @(posedge clk); #1;
    start_i = 0;
    @(negedge clk);
    n_cmp++;
    if ({done_o, busy_o, rd_en_o, m_valid_o} !== 4'b1100 || cnt_o !== 8'd0) begin
      n_bad++; $display("FAIL len0_done done=%b busy=%b rd=%b v=%b cnt=%0d exp 1 1 0 0 0", done_o, busy_o, rd_en_o, m_valid_o, cnt_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({done_o, busy_o, rd_en_o, m_valid_o} !== 4'b0000) begin
      n_bad++; $display("FAIL len0_idle done=%b busy=%b rd=%b v=%b exp 0 0 0 0", done_o, busy_o, rd_en_o, m_valid_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int fv, dc;
    for (int i = 0; i < 5; i++) preload(8'(8'h40 + i));
    run_burst(3, 0, 0, fv, dc);
    n_cmp++;
    if (fv != 3 || dc != 6) begin n_bad++; $display("FAIL b2b_first first_valid=%0d done=%0d exp 3 6", fv, dc); end
    run_burst(5, 0, 0, fv, dc);
    n_cmp++;
    if (fv != 3 || dc != 8) begin n_bad++; $display("FAIL b2b_second first_valid=%0d done=%0d exp 3 8", fv, dc); end
  endtask

  task automatic test_error;
    int fv, dc;
    for (int i = 0; i < 8; i++) preload(8'($urandom));
    run_burst(8, 2, 4, fv, dc);
    n_cmp++;
    if (error_o !== 1'b1) begin n_bad++; $display("FAIL error_set err=%b exp 1", error_o); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int fv, dc, rds;
    for (int i = 0; i < 8; i++) preload(8'(8'h60 + i));
    n_cmp++;
    if (error_o !== 1'b1) begin n_bad++; $display("FAIL error_sticky err=%b exp 1", error_o); end
    m_ready_i = 0;
    start_i = 1;
    len_i = 8;
    @(posedge clk); #1;
    start_i = 0;
    rds = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) rst_i = 0;
      @(negedge clk);
      if (rd_en_o) rds++;
      @(posedge clk); #1;
    end
    rst_i = 1;
    @(negedge clk);
    n_cmp++;
    if ({rd_en_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o, cnt_o, error_o} !== '0 || rds != 2) begin
      n_bad++; $display("FAIL reset_mid rd=%b v=%b d=%h l=%b busy=%b done=%b cnt=%0d err=%b reads=%0d exp all 0 reads=2",
        rd_en_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o, cnt_o, error_o, rds);
    end
    exp_idx += 2;
    @(posedge clk); #1;
    run_burst(2, 0, 0, fv, dc);
    n_cmp++;
    if (fv != 3 || dc != 5) begin n_bad++; $display("FAIL reset_restart first_valid=%0d done=%0d exp 3 5", fv, dc); end
  endtask

  task automatic test_random;
    int fv, dc, len, avail, need, k;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 20);
      avail = wlog.size() - exp_idx;
      need = len > avail ? len - avail : 0;
      k = need > 0 ? $urandom_range(0, need) : 0;
      for (int i = 0; i < k; i++) preload(8'($urandom));
      for (int i = k; i < need; i++) feed_q.push_back(8'($urandom));
      feed_gap = $urandom_range(1, 4);
      run_burst(len, 2, 0, fv, dc);
      feed_gap = 1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_empty_feed();
    test_len0();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
